// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO front end: integrates a tuning word and produces
// sine/cosine LUT addresses through a two-stage pipeline.
module nco_phase_gen #(
  parameter  int ADDR_MAX = 1024,
  parameter  int ACC_W    = 32,
  localparam int AW       = $clog2(ADDR_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic             ftw_load,
  input  logic [AW-1:0]    phase_off,
  input  logic             sync_clr,
  output logic [AW-1:0]    addr_I,
  output logic [AW-1:0]    addr_Q,
  output logic             addr_valid,
  output logic             wrap
);

  logic [ACC_W-1:0] acc, ftw_act, ftw_pend;
  logic             pend_flag;
  logic [2:1]       vld_pipe;
  logic [ACC_W:0]   sum;
  logic             step, carry, xfer;
  logic [AW-1:0]    ph, ph_off;

  assign sum   = {1'b0, acc} + {1'b0, ftw_act};
  assign carry = sum[ACC_W];
  assign step  = en & ~sync_clr;
  // Swap words only where the phase jump is invisible: at wrap, while idle, or on clear.
  assign xfer  = pend_flag & ((step & carry) | ~en | sync_clr);

  assign ph     = acc[ACC_W-1 -: AW];
  assign ph_off = ph + phase_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      wrap     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (sync_clr)  acc <= '0;
      else if (en)   acc <= sum[ACC_W-1:0];
      wrap        <= step & carry;
      vld_pipe[1] <= step;
      vld_pipe[2] <= vld_pipe[1];
    end
  end

  // A load coinciding with a transfer stays pending; the transfer takes the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_act   <= '0;
      ftw_pend  <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (xfer)          ftw_act  <= ftw_pend;
      if (ftw_load)      ftw_pend <= ftw_in;
      if (ftw_load)      pend_flag <= 1'b1;
      else if (xfer)     pend_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_Q <= '0;
      addr_I <= '0;
    end else begin
      addr_Q <= ph_off;
      addr_I <= ph_off + AW'(ADDR_MAX / 4);
    end
  end

  assign addr_valid = vld_pipe[2];

endmodule
